rs_mem_issue_ctrl: RTL and testbench
====================================

Name: rs_mem_issue_ctrl

Overview:
- Allocation and issue controller for the access-memory reservation station.
- Sits between dispatch and the array of access-memory RS entries.
- Dispatch side: hands out free entry slots in program order and drives each entry's busy/write-enable.
- Issue side: reads the entries' ready flags and issues strictly in program order (oldest first) to the load/store unit with a valid/ready handshake, so memory ordering is preserved.

Parameters:
- ENTRY_NUM, 4, number of RS entries; power of two, ≥2.
- ENTRY_SEL, 2, log2(ENTRY_NUM); index width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- alloc_req_i  in  1  dispatch requests one entry this cycle
- alloc_ok_o  out  1  an entry is free; allocation accepted when alloc_req_i & alloc_ok_o
- alloc_idx_o  out  ENTRY_SEL  index of the entry being allocated (tail)
- wen_o  out  ENTRY_NUM  one-hot write enable to entries; bit tail set on allocation fire
- busy_o  out  ENTRY_NUM  per-entry occupied flag, drives each entry's busy_i
- ready_vec_i  in  ENTRY_NUM  per-entry ready_o from the entries
- issue_valid_o  out  1  head entry is busy and ready
- issue_idx_o  out  ENTRY_SEL  head index; selects the entry's operands, pc, imm and tag
- exe_ready_i  in  1  load/store unit accepts an instruction this cycle
- flush_i  in  1  mispredict kill; empties the station
- count_o  out  ENTRY_SEL+1  number of occupied entries
- full_o  out  1  count_o == ENTRY_NUM
- empty_o  out  1  count_o == 0

Behaviour:
- State registers:
  - head, tail: ENTRY_SEL wide, wrap modulo ENTRY_NUM.
  - count: ENTRY_SEL+1 wide.
  - busy: ENTRY_NUM bits.
- Reset (reset_i high at a clock edge): head=0, tail=0, count=0, busy=0.
  - Resulting outputs: busy_o=0, alloc_ok_o=1, alloc_idx_o=0, issue_valid_o=0, issue_idx_o=0, full_o=0, empty_o=1, count_o=0, wen_o=0.
- Allocation:
  - alloc_ok_o = ~full (current count only; an issue in the same cycle does not free a slot for that cycle).
  - alloc_fire = alloc_req_i & alloc_ok_o & ~flush_i.
  - wen_o = alloc_fire ? (1 << tail) : 0, combinational in the same cycle as the request, so the entry captures its payload on that edge.
  - Next edge: busy[tail] set, tail+1 (wraps ENTRY_NUM-1 → 0).
- Issue:
  - issue_valid_o = busy[head] & ready_vec_i[head] & ~flush_i; issue_idx_o = head. Both combinational.
  - Younger ready entries never issue ahead of the head (in-order memory issue).
  - issue_fire = issue_valid_o & exe_ready_i.
  - Next edge: busy[head] cleared, head+1 with wrap.
  - issue_valid_o may rise without exe_ready_i; while stalled, head and busy hold. No requirement that valid stays high if the entry's ready drops.
- Count: count_next = count + alloc_fire − issue_fire.
  - Simultaneous alloc and issue leaves count unchanged; head and tail both advance.
  - When head == tail with count = 0 and alloc fires, the new entry cannot issue in the same cycle because busy is not yet set. Issue is earliest one cycle after allocation.
- Flush: flush_i high at an edge sets busy=0, head=0, tail=0, count=0.
  - Flush has priority over alloc and issue in the same cycle; neither fires (wen_o=0, issue_valid_o=0).
  - Reset has priority over flush.
- Invariant: popcount(busy) == count at all times; busy bits set only at tail, cleared only at head.
- Latency: alloc → earliest issue = 1 cycle (entry valid flags register on the alloc edge).

Test Plan:
- Reset then 4 consecutive allocs (alloc_req_i=1, ready_vec_i=0) → wen_o = 0001, 0010, 0100, 1000; full_o=1, alloc_ok_o=0; 5th request is not accepted and wen_o=0.
- Full station, ready_vec_i=1111, exe_ready_i=1 → issue_idx_o = 0,1,2,3 on successive cycles; empty_o=1 after the 4th; busy_o=0000.
- In-order check: entries 0 and 1 busy, ready_vec_i=0010 → issue_valid_o=0; set bit 0 → issue idx 0, then idx 1 next cycle.
- Backpressure: head ready, exe_ready_i=0 for 3 cycles → issue_valid_o held at 1, head/count unchanged; exe_ready_i=1 → single issue, count decrements by 1.
- Simultaneous alloc+issue with count=2 and head=3 (tail=1) → count stays 2; head wraps to 0; tail=2; wen_o=0010.
- Flush with count=3 plus concurrent alloc_req_i and a ready head → wen_o=0, issue_valid_o=0; next cycle busy_o=0, head=tail=0, count_o=0, alloc_ok_o=1.

Source files
------------

// File: rtl/rs_mem_issue_ctrl_if.sv
// Signal bundle between dispatch, the access-memory RS entries, the load/store
// unit and the in-order allocation/issue controller.
interface rs_mem_issue_ctrl_if #(
  parameter int ENTRY_NUM = 4,
  parameter int ENTRY_SEL = 2
);
  logic                 alloc_req_i;
  logic                 alloc_ok_o;
  logic [ENTRY_SEL-1:0] alloc_idx_o;
  logic [ENTRY_NUM-1:0] wen_o;
  logic [ENTRY_NUM-1:0] busy_o;
  logic [ENTRY_NUM-1:0] ready_vec_i;
  logic                 issue_valid_o;
  logic [ENTRY_SEL-1:0] issue_idx_o;
  logic                 exe_ready_i;
  logic                 flush_i;
  logic [ENTRY_SEL:0]   count_o;
  logic                 full_o;
  logic                 empty_o;

  // Controller side
  modport slave (
    input  alloc_req_i, ready_vec_i, exe_ready_i, flush_i,
    output alloc_ok_o, alloc_idx_o, wen_o, busy_o, issue_valid_o,
           issue_idx_o, count_o, full_o, empty_o
  );

  // Dispatch / entries / LSU side
  modport master (
    output alloc_req_i, ready_vec_i, exe_ready_i, flush_i,
    input  alloc_ok_o, alloc_idx_o, wen_o, busy_o, issue_valid_o,
           issue_idx_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/rs_mem_issue_ctrl.sv
// Access-memory reservation station controller: allocates entries in program
// order at the tail and issues strictly oldest-first from the head.
module rs_mem_issue_ctrl #(
  parameter int ENTRY_NUM = 4,
  parameter int ENTRY_SEL = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  rs_mem_issue_ctrl_if.slave  bus
);

  localparam logic [ENTRY_SEL:0]   FULL_CNT = (ENTRY_SEL+1)'(ENTRY_NUM);
  localparam logic [ENTRY_NUM-1:0] ONE_HOT0 = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

  logic [ENTRY_SEL-1:0] r_head;
  logic [ENTRY_SEL-1:0] r_tail;
  logic [ENTRY_SEL:0]   r_count;
  logic [ENTRY_NUM-1:0] r_busy;

  logic                 w_full;
  logic                 w_alloc_ok;
  logic                 w_alloc_fire;
  logic                 w_issue_valid;
  logic                 w_issue_fire;
  logic [ENTRY_NUM-1:0] w_wen;
  logic [ENTRY_NUM-1:0] w_clr;
  logic [ENTRY_SEL:0]   w_count_next;

  // Handshake decode; flush suppresses both alloc and issue in its cycle
  always_comb begin
    w_full        = (r_count == FULL_CNT);
    w_alloc_ok    = ~w_full;
    w_alloc_fire  = bus.alloc_req_i & w_alloc_ok & ~bus.flush_i;
    w_issue_valid = r_busy[r_head] & bus.ready_vec_i[r_head] & ~bus.flush_i;
    w_issue_fire  = w_issue_valid & bus.exe_ready_i;
    w_wen         = {ENTRY_NUM{1'b0}};
    w_clr         = {ENTRY_NUM{1'b0}};
    if (w_alloc_fire) begin
      w_wen = ONE_HOT0 << r_tail;
    end else begin
      w_wen = {ENTRY_NUM{1'b0}};
    end
    if (w_issue_fire) begin
      w_clr = ONE_HOT0 << r_head;
    end else begin
      w_clr = {ENTRY_NUM{1'b0}};
    end
    w_count_next = r_count + {{ENTRY_SEL{1'b0}}, w_alloc_fire}
                           - {{ENTRY_SEL{1'b0}}, w_issue_fire};
  end

  // Pointer, occupancy and busy-vector state; head/tail wrap naturally
  always_ff @(posedge clk_i) begin
    if (reset_i || bus.flush_i) begin
      r_head  <= {ENTRY_SEL{1'b0}};
      r_tail  <= {ENTRY_SEL{1'b0}};
      r_count <= {(ENTRY_SEL+1){1'b0}};
      r_busy  <= {ENTRY_NUM{1'b0}};
    end else begin
      r_count <= w_count_next;
      r_busy  <= (r_busy & ~w_clr) | w_wen;
      if (w_alloc_fire) begin
        r_tail <= r_tail + {{(ENTRY_SEL-1){1'b0}}, 1'b1};
      end
      if (w_issue_fire) begin
        r_head <= r_head + {{(ENTRY_SEL-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.alloc_ok_o    = w_alloc_ok;
  assign bus.alloc_idx_o   = r_tail;
  assign bus.wen_o         = w_wen;
  assign bus.busy_o        = r_busy;
  assign bus.issue_valid_o = w_issue_valid;
  assign bus.issue_idx_o   = r_head;
  assign bus.count_o       = r_count;
  assign bus.full_o        = w_full;
  assign bus.empty_o       = (r_count == {(ENTRY_SEL+1){1'b0}});

endmodule

// File: tb/tb_rs_mem_issue_ctrl.sv
// Directed bench for rs_mem_issue_ctrl with hand-computed expectations.
module tb_rs_mem_issue_ctrl;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_tests = 0;
  int   n_fail  = 0;

  rs_mem_issue_ctrl_if #(.ENTRY_NUM(4), .ENTRY_SEL(2)) bus ();

  rs_mem_issue_ctrl #(.ENTRY_NUM(4), .ENTRY_SEL(2)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle combinational outputs away from the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i         = 1'b1;
    bus.alloc_req_i = 1'b0;
    bus.ready_vec_i = 4'b0000;
    bus.exe_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    settle();
    check_eq("rst_busy",     32'(bus.busy_o),        32'h0);
    check_eq("rst_alloc_ok", 32'(bus.alloc_ok_o),    32'h1);
    check_eq("rst_alloc_idx",32'(bus.alloc_idx_o),   32'h0);
    check_eq("rst_iss_vld",  32'(bus.issue_valid_o), 32'h0);
    check_eq("rst_iss_idx",  32'(bus.issue_idx_o),   32'h0);
    check_eq("rst_full",     32'(bus.full_o),        32'h0);
    check_eq("rst_empty",    32'(bus.empty_o),       32'h1);
    check_eq("rst_count",    32'(bus.count_o),       32'h0);
    check_eq("rst_wen",      32'(bus.wen_o),         32'h0);

    // Fill the station
    bus.alloc_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("fill_wen", 32'(bus.wen_o), 32'h1 << i);
      check_eq("fill_idx", 32'(bus.alloc_idx_o), 32'(i));
      step();
    end
    settle();
    check_eq("full_flag",  32'(bus.full_o),     32'h1);
    check_eq("full_ok",    32'(bus.alloc_ok_o), 32'h0);
    check_eq("full_wen",   32'(bus.wen_o),      32'h0);
    check_eq("full_count", 32'(bus.count_o),    32'h4);
    check_eq("full_busy",  32'(bus.busy_o),     32'hf);
    step();
    check_eq("full_count2",32'(bus.count_o),    32'h4);
    bus.alloc_req_i = 1'b0;

    // Drain in order
    bus.ready_vec_i = 4'b1111;
    bus.exe_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("drain_vld", 32'(bus.issue_valid_o), 32'h1);
      check_eq("drain_idx", 32'(bus.issue_idx_o),   32'(i));
      step();
    end
    settle();
    check_eq("drain_empty", 32'(bus.empty_o),       32'h1);
    check_eq("drain_busy",  32'(bus.busy_o),        32'h0);
    check_eq("drain_vld0",  32'(bus.issue_valid_o), 32'h0);
    bus.ready_vec_i = 4'b0000;
    bus.exe_ready_i = 1'b0;

    // In-order: younger ready entry must not bypass the head
    bus.alloc_req_i = 1'b1;
    step();
    step();
    bus.alloc_req_i = 1'b0;
    bus.ready_vec_i = 4'b0010;
    bus.exe_ready_i = 1'b1;
    settle();
    check_eq("ord_blocked", 32'(bus.issue_valid_o), 32'h0);
    step();
    check_eq("ord_count",   32'(bus.count_o),       32'h2);
    bus.ready_vec_i = 4'b0011;
    settle();
    check_eq("ord_vld0",    32'(bus.issue_valid_o), 32'h1);
    check_eq("ord_idx0",    32'(bus.issue_idx_o),   32'h0);
    step();
    check_eq("ord_vld1",    32'(bus.issue_valid_o), 32'h1);
    check_eq("ord_idx1",    32'(bus.issue_idx_o),   32'h1);
    step();
    check_eq("ord_empty",   32'(bus.empty_o),       32'h1);
    bus.ready_vec_i = 4'b0000;
    bus.exe_ready_i = 1'b0;

    // Backpressure on entry 2
    bus.alloc_req_i = 1'b1;
    step();
    bus.alloc_req_i = 1'b0;
    bus.ready_vec_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("bp_vld",   32'(bus.issue_valid_o), 32'h1);
      check_eq("bp_idx",   32'(bus.issue_idx_o),   32'h2);
      check_eq("bp_count", 32'(bus.count_o),       32'h1);
      step();
    end
    bus.exe_ready_i = 1'b1;
    step();
    check_eq("bp_count0", 32'(bus.count_o),     32'h0);
    check_eq("bp_head",   32'(bus.issue_idx_o), 32'h3);
    bus.exe_ready_i = 1'b0;
    bus.ready_vec_i = 4'b0000;

    // Simultaneous alloc + issue with head=3, tail=1, count=2
    bus.alloc_req_i = 1'b1;
    step();
    step();
    check_eq("sim_pre_cnt", 32'(bus.count_o),     32'h2);
    check_eq("sim_pre_tl",  32'(bus.alloc_idx_o), 32'h1);
    bus.ready_vec_i = 4'b1000;
    bus.exe_ready_i = 1'b1;
    settle();
    check_eq("sim_wen",  32'(bus.wen_o),         32'h2);
    check_eq("sim_vld",  32'(bus.issue_valid_o), 32'h1);
    check_eq("sim_idx",  32'(bus.issue_idx_o),   32'h3);
    step();
    bus.alloc_req_i = 1'b0;
    bus.ready_vec_i = 4'b0000;
    bus.exe_ready_i = 1'b0;
    settle();
    check_eq("sim_count", 32'(bus.count_o),     32'h2);
    check_eq("sim_head",  32'(bus.issue_idx_o), 32'h0);
    check_eq("sim_tail",  32'(bus.alloc_idx_o), 32'h2);
    check_eq("sim_busy",  32'(bus.busy_o),      32'h3);

    // Flush with count=3 plus concurrent alloc and ready head
    bus.alloc_req_i = 1'b1;
    step();
    check_eq("fl_pre_cnt",  32'(bus.count_o), 32'h3);
    bus.flush_i     = 1'b1;
    bus.ready_vec_i = 4'b1111;
    bus.exe_ready_i = 1'b1;
    settle();
    check_eq("fl_wen", 32'(bus.wen_o),         32'h0);
    check_eq("fl_vld", 32'(bus.issue_valid_o), 32'h0);
    step();
    bus.flush_i     = 1'b0;
    bus.alloc_req_i = 1'b0;
    bus.ready_vec_i = 4'b0000;
    bus.exe_ready_i = 1'b0;
    settle();
    check_eq("fl_busy",  32'(bus.busy_o),      32'h0);
    check_eq("fl_count", 32'(bus.count_o),     32'h0);
    check_eq("fl_head",  32'(bus.issue_idx_o), 32'h0);
    check_eq("fl_tail",  32'(bus.alloc_idx_o), 32'h0);
    check_eq("fl_ok",    32'(bus.alloc_ok_o),  32'h1);

    // Newly allocated entry issues one cycle later, not in the alloc cycle
    bus.alloc_req_i = 1'b1;
    bus.ready_vec_i = 4'b1111;
    settle();
    check_eq("lat_same", 32'(bus.issue_valid_o), 32'h0);
    step();
    bus.alloc_req_i = 1'b0;
    settle();
    check_eq("lat_next", 32'(bus.issue_valid_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
